// File: rtl/age_ordered_rs_if.sv
// Dispatch, wakeup, issue and flush signals of the age-ordered reservation station.
interface age_ordered_rs_if #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int PAYLOAD_W = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                           enq_valid;
  logic                           enq_ready;
  logic [ROB_IDX_W-1:0]           enq_rob_id;
  logic [PRF_IDX_W-1:0]           enq_rs1_phy;
  logic [PRF_IDX_W-1:0]           enq_rs2_phy;
  logic                           enq_rs1_ready;
  logic                           enq_rs2_ready;
  logic [PAYLOAD_W-1:0]           enq_payload;
  logic [CDB_WIDTH-1:0]           cdb_valid;
  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy;
  logic                           issue_valid;
  logic                           issue_ready;
  logic [ROB_IDX_W-1:0]           issue_rob_id;
  logic [PRF_IDX_W-1:0]           issue_rs1_phy;
  logic [PRF_IDX_W-1:0]           issue_rs2_phy;
  logic [PAYLOAD_W-1:0]           issue_payload;
  logic                           flush;
  logic [CNT_W-1:0]               occupancy;

  modport slave (
    input  enq_valid, enq_rob_id, enq_rs1_phy, enq_rs2_phy, enq_rs1_ready, enq_rs2_ready,
           enq_payload, cdb_valid, cdb_rd_phy, issue_ready, flush,
    output enq_ready, issue_valid, issue_rob_id, issue_rs1_phy, issue_rs2_phy,
           issue_payload, occupancy
  );

  modport master (
    output enq_valid, enq_rob_id, enq_rs1_phy, enq_rs2_phy, enq_rs1_ready, enq_rs2_ready,
           enq_payload, cdb_valid, cdb_rd_phy, issue_ready, flush,
    input  enq_ready, issue_valid, issue_rob_id, issue_rs1_phy, issue_rs2_phy,
           issue_payload, occupancy
  );
endinterface

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: CDB wakeup, oldest-ready issue via an age matrix,
// full flush and registered occupancy.
module age_ordered_rs #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int PAYLOAD_W = 64
) (
  input logic             clk,
  input logic             rst,
  age_ordered_rs_if.slave rs
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rs1_rdy;
  logic [DEPTH-1:0]     rs2_rdy;
  logic [DEPTH-1:0]     age [DEPTH];
  logic [ROB_IDX_W-1:0] rob_id [DEPTH];
  logic [PRF_IDX_W-1:0] rs1_phy [DEPTH];
  logic [PRF_IDX_W-1:0] rs2_phy [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [CNT_W-1:0]     occ;

  logic [DEPTH-1:0]     req;
  logic [DEPTH-1:0]     grant;
  logic [DEPTH-1:0]     enq_oh;
  logic [DEPTH-1:0]     rs1_hit;
  logic [DEPTH-1:0]     rs2_hit;
  logic                 enq_rs1_hit;
  logic                 enq_rs2_hit;
  logic                 enq_fire;
  logic                 issue_fire;
  logic [ROB_IDX_W-1:0] sel_rob;
  logic [PRF_IDX_W-1:0] sel_rs1;
  logic [PRF_IDX_W-1:0] sel_rs2;
  logic [PAYLOAD_W-1:0] sel_payload;

  function automatic logic cdb_match(input logic [PRF_IDX_W-1:0]           phy,
                                     input logic [CDB_WIDTH-1:0]           vld,
                                     input logic [CDB_WIDTH*PRF_IDX_W-1:0] rd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++)
      if (vld[k] && rd[k*PRF_IDX_W +: PRF_IDX_W] == phy) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    rs1_hit     = '0;
    rs2_hit     = '0;
    enq_rs1_hit = cdb_match(rs.enq_rs1_phy, rs.cdb_valid, rs.cdb_rd_phy);
    enq_rs2_hit = cdb_match(rs.enq_rs2_phy, rs.cdb_valid, rs.cdb_rd_phy);
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit[i] = cdb_match(rs1_phy[i], rs.cdb_valid, rs.cdb_rd_phy);
      rs2_hit[i] = cdb_match(rs2_phy[i], rs.cdb_valid, rs.cdb_rd_phy);
    end
  end

  // An entry wins only if no other requester is older than it.
  always_comb begin
    req   = valid & rs1_rdy & rs2_rdy;
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && req[j] && age[j][i]) grant[i] = 1'b0;
    end
  end

  always_comb begin
    sel_rob     = '0;
    sel_rs1     = '0;
    sel_rs2     = '0;
    sel_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_rob     = sel_rob     | ({ROB_IDX_W{grant[i]}} & rob_id[i]);
      sel_rs1     = sel_rs1     | ({PRF_IDX_W{grant[i]}} & rs1_phy[i]);
      sel_rs2     = sel_rs2     | ({PRF_IDX_W{grant[i]}} & rs2_phy[i]);
      sel_payload = sel_payload | ({PAYLOAD_W{grant[i]}} & payload[i]);
    end
  end

  // Lowest clear bit of the start-of-cycle valid vector; slots freed by issue wait a cycle.
  assign enq_oh     = ~valid & (valid + DEPTH'(1));
  assign enq_fire   = rs.enq_valid && rs.enq_ready && !rs.flush;
  assign issue_fire = rs.issue_valid && rs.issue_ready;

  assign rs.enq_ready     = (occ < CNT_W'(DEPTH));
  assign rs.issue_valid   = (|req) && !rs.flush;
  assign rs.issue_rob_id  = sel_rob;
  assign rs.issue_rs1_phy = sel_rs1;
  assign rs.issue_rs2_phy = sel_rs2;
  assign rs.issue_payload = sel_payload;
  assign rs.occupancy     = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      occ   <= '0;
    end else if (rs.flush) begin
      valid <= '0;
      occ   <= '0;
    end else begin
      valid <= (valid & ~({DEPTH{issue_fire}} & grant)) | ({DEPTH{enq_fire}} & enq_oh);
      occ   <= occ + CNT_W'(enq_fire) - CNT_W'(issue_fire);
    end
  end

  // Entry contents and age rows: meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && enq_oh[i]) begin
        rob_id[i]  <= rs.enq_rob_id;
        rs1_phy[i] <= rs.enq_rs1_phy;
        rs2_phy[i] <= rs.enq_rs2_phy;
        payload[i] <= rs.enq_payload;
        rs1_rdy[i] <= rs.enq_rs1_ready | enq_rs1_hit;
        rs2_rdy[i] <= rs.enq_rs2_ready | enq_rs2_hit;
        age[i]     <= '0;
      end else begin
        if (rs1_hit[i]) rs1_rdy[i] <= 1'b1;
        if (rs2_hit[i]) rs2_rdy[i] <= 1'b1;
        if (enq_fire && valid[i]) age[i] <= age[i] | enq_oh;
      end
    end
  end
endmodule

// File: tb/tb_age_ordered_rs.sv
// Bench for age_ordered_rs: sequence-number reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_age_ordered_rs;
  localparam int DEPTH = 8, CDBW = 2, PW = 6, RW = 5, DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  age_ordered_rs_if #(.DEPTH(DEPTH), .CDB_WIDTH(CDBW), .PRF_IDX_W(PW),
                      .ROB_IDX_W(RW), .PAYLOAD_W(DW)) bus ();

  age_ordered_rs #(.DEPTH(DEPTH), .CDB_WIDTH(CDBW), .PRF_IDX_W(PW),
                   .ROB_IDX_W(RW), .PAYLOAD_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each live uop carries a global arrival number; smaller = older.
  bit          m_v   [DEPTH];
  int          m_seq [DEPTH];
  logic [RW-1:0] m_rob [DEPTH];
  logic [PW-1:0] m_p1  [DEPTH];
  logic [PW-1:0] m_p2  [DEPTH];
  bit          m_r1  [DEPTH];
  bit          m_r2  [DEPTH];
  logic [DW-1:0] m_pl  [DEPTH];
  int          m_next = 0;
  int          m_cnt, m_sel, m_free;
  bit          m_iv;

  function automatic bit on_cdb(input logic [PW-1:0] p);
    bit h = 0;
    for (int k = 0; k < CDBW; k++)
      if (bus.cdb_valid[k] && bus.cdb_rd_phy[k*PW +: PW] == p) h = 1;
    return h;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_occupancy",   64'(bus.occupancy),   64'd0);
      chk("rst_enq_ready",   64'(bus.enq_ready),   64'd1);
      chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    end else begin
      m_cnt = 0;
      m_sel = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i]) m_cnt++;
        if (m_v[i] && m_r1[i] && m_r2[i] && (m_sel < 0 || m_seq[i] < m_seq[m_sel])) m_sel = i;
      end
      m_iv = (m_sel >= 0) && !bus.flush;
      chk("occupancy",   64'(bus.occupancy),   64'(m_cnt));
      chk("enq_ready",   64'(bus.enq_ready),   64'(m_cnt < DEPTH));
      chk("issue_valid", 64'(bus.issue_valid), 64'(m_iv));
      if (m_iv) begin
        chk("issue_rob_id",  64'(bus.issue_rob_id),  64'(m_rob[m_sel]));
        chk("issue_rs1_phy", 64'(bus.issue_rs1_phy), 64'(m_p1[m_sel]));
        chk("issue_rs2_phy", 64'(bus.issue_rs2_phy), 64'(m_p2[m_sel]));
        chk("issue_payload", bus.issue_payload,      m_pl[m_sel]);
      end
      m_free = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) m_free = i;
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (on_cdb(m_p1[i])) m_r1[i] = 1;
          if (on_cdb(m_p2[i])) m_r2[i] = 1;
        end
        if (m_iv && bus.issue_ready) m_v[m_sel] = 0;
        if (bus.enq_valid && m_cnt < DEPTH) begin
          m_v[m_free]   = 1;
          m_seq[m_free] = m_next++;
          m_rob[m_free] = bus.enq_rob_id;
          m_p1[m_free]  = bus.enq_rs1_phy;
          m_p2[m_free]  = bus.enq_rs2_phy;
          m_r1[m_free]  = bus.enq_rs1_ready || on_cdb(bus.enq_rs1_phy);
          m_r2[m_free]  = bus.enq_rs2_ready || on_cdb(bus.enq_rs2_phy);
          m_pl[m_free]  = bus.enq_payload;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_valid     = 1'b0;
    bus.enq_rob_id    = '0;
    bus.enq_rs1_phy   = '0;
    bus.enq_rs2_phy   = '0;
    bus.enq_rs1_ready = 1'b0;
    bus.enq_rs2_ready = 1'b0;
    bus.enq_payload   = '0;
    bus.cdb_valid     = '0;
    bus.cdb_rd_phy    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic enq(input int rob, input int p1, input bit r1, input int p2, input bit r2);
    bus.enq_valid     = 1'b1;
    bus.enq_rob_id    = RW'(rob);
    bus.enq_rs1_phy   = PW'(p1);
    bus.enq_rs1_ready = r1;
    bus.enq_rs2_phy   = PW'(p2);
    bus.enq_rs2_ready = r2;
    bus.enq_payload   = {$urandom, $urandom};
  endtask

  task automatic cdb(input int ch, input int phy);
    bus.cdb_valid[ch]            = 1'b1;
    bus.cdb_rd_phy[ch*PW +: PW]  = PW'(phy);
  endtask

  task automatic expect_issue(input string name, input int rob);
    #2;
    chk({name, "_valid"}, 64'(bus.issue_valid), 64'd1);
    chk({name, "_rob"},   64'(bus.issue_rob_id), 64'(rob));
  endtask

  initial begin
    idle();
    bus.issue_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #2;
    chk("idle_occupancy",   64'(bus.occupancy),   64'd0);
    chk("idle_enq_ready",   64'(bus.enq_ready),   64'd1);
    chk("idle_issue_valid", 64'(bus.issue_valid), 64'd0);
    tick();

    // Two ready uops issue in arrival order, first one the cycle after its enqueue.
    bus.issue_ready = 1'b1;
    enq(3, 1, 1, 2, 1); tick();
    enq(4, 1, 1, 2, 1); expect_issue("order_first", 3); tick();
    idle();             expect_issue("order_second", 4); tick();
    #2 chk("order_drained", 64'(bus.issue_valid), 64'd0);
    tick();

    // Older uop woken by CDB channel 1 beats a younger ready uop.
    enq(5, 12, 0, 2, 1); tick();
    enq(6, 1, 1, 2, 1); cdb(1, 12);
    #2 chk("wake_not_yet", 64'(bus.issue_valid), 64'd0);
    tick();
    idle(); expect_issue("wake_older", 5); tick();
    expect_issue("wake_younger", 6); tick();

    // Fill all entries, wake entry 2, and refill it with a uop that must be youngest.
    for (int i = 0; i < DEPTH; i++) begin
      enq(i, 20 + i, 0, 2, 1); tick();
    end
    idle();
    #2;
    chk("full_occupancy", 64'(bus.occupancy), 64'd8);
    chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    cdb(0, 22); tick();
    idle(); expect_issue("full_wake2", 2); tick();
    #2;
    chk("refill_enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("refill_occupancy", 64'(bus.occupancy), 64'd7);
    enq(20, 1, 1, 2, 1); cdb(0, 20); tick();
    idle(); expect_issue("refill_older", 0); tick();
    expect_issue("refill_youngest", 20); tick();
    bus.flush = 1'b1; tick();
    idle();
    #2 chk("cleanup_occupancy", 64'(bus.occupancy), 64'd0);
    tick();

    // Source woken by a broadcast in its own enqueue cycle.
    enq(9, 1, 1, 7, 0); cdb(0, 7); tick();
    idle(); expect_issue("enq_bypass", 9); tick();

    // Flush with a concurrent enqueue while ready entries wait.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq(10 + i, 1, 1, 2, 1); tick();
    end
    idle();
    #2 chk("preflush_occupancy", 64'(bus.occupancy), 64'd5);
    bus.flush = 1'b1;
    enq(30, 1, 1, 2, 1);
    #1 chk("flush_blocks_issue", 64'(bus.issue_valid), 64'd0);
    tick();
    idle();
    #2;
    chk("postflush_occupancy", 64'(bus.occupancy),   64'd0);
    chk("postflush_issue",     64'(bus.issue_valid), 64'd0);
    tick();
    #2 chk("flush_uop_dropped", 64'(bus.issue_valid), 64'd0);
    tick();

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(2) != 0)
        enq($urandom_range(31), $urandom_range(15), ($urandom_range(2) == 0),
            $urandom_range(15), ($urandom_range(2) == 0));
      for (int k = 0; k < CDBW; k++)
        if ($urandom_range(1) == 1) cdb(k, $urandom_range(15));
      bus.issue_ready = ($urandom_range(3) != 0);
      bus.flush       = ($urandom_range(63) == 0);
      rst             = (c == 1500 || c == 1501);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised, age-ordered reservation station for the out-of-order backend. It generalises the single-purpose branch station to any functional unit. Uops enter from dispatch with a pass-through payload and wait for operand wakeup from `CDB_WIDTH` broadcast channels. The oldest entry with both operands ready issues first. The block also supports a full flush on misprediction and reports its occupancy.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `CDB_WIDTH`, 2: number of wakeup broadcast channels.
- `PRF_IDX_W`, 6: physical-register index width.
- `ROB_IDX_W`, 5: ROB id width.
- `PAYLOAD_W`, 64: opaque payload width (opcode, imm, pc, rd, prediction); not interpreted.

Ports:
- `clk`  in  1  sole clock; everything on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enq_valid`  in  1  dispatch offers a uop.
- `enq_ready`  out  1  the station can accept a uop.
- `enq_rob_id`  in  ROB_IDX_W  ROB id of the offered uop.
- `enq_rs1_phy`, `enq_rs2_phy`  in  PRF_IDX_W each  source physical registers.
- `enq_rs1_ready`, `enq_rs2_ready`  in  1 each  source already available at dispatch.
- `enq_payload`  in  PAYLOAD_W  pass-through data.
- `cdb_valid`  in  CDB_WIDTH  per-channel broadcast valid.
- `cdb_rd_phy`  in  CDB_WIDTH*PRF_IDX_W  per-channel destination; channel k occupies bits [k*PRF_IDX_W +: PRF_IDX_W].
- `issue_valid`  out  1  an entry is selected for issue.
- `issue_ready`  in  1  the functional unit accepts the selected entry.
- `issue_rob_id`, `issue_rs1_phy`, `issue_rs2_phy`, `issue_payload`  out  as the enq_ fields  fields of the selected entry.
- `flush`  in  1  misprediction; kill all entries.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Each entry holds: valid, rob_id, rs1/rs2 phy, rs1/rs2 ready, payload.
- Age matrix: DEPTH×DEPTH flops. Bit [i][j]=1 means entry i is older than entry j.
- Enqueue fires when `enq_valid && enq_ready && !flush`.
  - The uop is written to the lowest-indexed entry that is invalid at the start of the cycle. An entry freed by issue in the same cycle is not reused until the next cycle.
  - On enqueue into entry n, row n is cleared and column n is set for every currently valid entry; the new uop is youngest.
- Wakeup:
  - For every valid entry and every channel k with `cdb_valid[k]`, a source whose phy equals `cdb_rd_phy[k]` sets its ready bit.
  - The same compare is applied to the incoming uop. A source that matches a CDB broadcast in the enqueue cycle is stored ready.
- Request: entry valid && rs1 ready && rs2 ready.
- Select: the requesting entry i for which no other requesting entry j has [j][i]=1, i.e. the oldest requester. The selection is one-hot, and the issue fields are a one-hot mux of it.
- `issue_valid` = any request && !flush.
- Issue fires when `issue_valid && issue_ready`. The selected entry's valid clears at the edge. If `issue_ready` is low, the selection is re-evaluated each cycle; an older entry that becomes ready may pre-empt the current one.
- Flush clears every valid bit at the edge. Flush has priority over enqueue and issue in the same cycle. Age bits need not be cleared.
- `enq_ready` = occupancy < DEPTH. It is not combinationally dependent on `issue_ready`.
- `occupancy` is a registered counter: +1 on enqueue, −1 on issue, net 0 on both, forced to 0 on flush. It must always equal the popcount of the valid bits.

## Timing
- Reset values: valids 0, occupancy 0, `enq_ready` 1, `issue_valid` 0. The issue_* data outputs are don't-care while `issue_valid` is 0.
- An uop enqueued ready at edge T can raise `issue_valid` in cycle T+1, which is the minimum latency.
- A CDB broadcast in cycle T wakes an entry at edge T; the entry can issue in cycle T+1.
- There is no combinational path from `cdb_*` to `issue_valid`.
- Full: with DEPTH entries valid, `enq_ready`=0. It returns to 1 in the cycle after an issue handshake.
- Multiple CDB channels may match the same source in one cycle; the result is the same as a single match.
- If `rst` is asserted mid-operation, all state clears immediately, without waiting for a clock edge.

## Test plan
- Reset then idle -> `occupancy`=0, `enq_ready`=1, `issue_valid`=0.
- Enqueue rob 3 (ready), rob 4 (ready) on consecutive cycles, `issue_ready`=1 -> issue order is rob 3 then rob 4, one per cycle starting the cycle after the first enqueue.
- Enqueue rob 5 (rs1=p12 not ready), then rob 6 (ready); broadcast p12 on CDB channel 1 in the cycle rob 6 enqueues -> rob 5 issues first in the next cycle because it is older.
- Fill 8 entries, none ready -> `enq_ready`=0, `occupancy`=8. Wake entry 2 and issue it -> the next enqueue lands in entry 2 and is youngest.
- Enqueue with rs2=p7 while CDB channel 0 broadcasts p7 in the same cycle -> the entry is ready and issues the next cycle.
- 5 entries valid, assert `flush` together with `enq_valid` -> next cycle `occupancy`=0, no issue, the flushed-cycle uop is not stored.
